alu_share_ctrl: RTL and testbench
=================================

Name: alu_share_ctrl

Overview:
Two-requester controller that shares the single registered ALU between the CPU datapath (port 0) and the debug/self-test unit (port 1). It accepts one operation at a time through a valid/ready handshake and arbitrates round-robin. It drives the ALU operand and control inputs, captures the result after the ALU's one-cycle register latency, and returns the result to the granted requester through a valid/ready response handshake. It also screens illegal opcodes and masks the overflow flag for operations where overflow is meaningless.

Parameters:
WIDTH, 32, operand/result width
TAG_W, 4, requester transaction tag width, echoed unchanged in the response

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high
req0_valid / req1_valid  in  1  request valid
req0_ready / req1_ready  out  1  request accepted this cycle
req0_op / req1_op  in  4  ALU control code
req0_a, req0_b / req1_a, req1_b  in  WIDTH  operands
req0_tag / req1_tag  in  TAG_W  transaction tag
rsp0_valid / rsp1_valid  out  1  response valid
rsp0_ready / rsp1_ready  in  1  response consumed
rsp_result  out  WIDTH  result (shared bus; qualified by rspN_valid)
rsp_zero  out  1  zero flag
rsp_overflow  out  1  overflow flag, masked
rsp_err  out  1  illegal opcode
rsp_tag  out  TAG_W  echoed tag
alu_a, alu_b  out  WIDTH  to ALU operand_A/operand_B
alu_ctrl  out  4  to ALU alu_control
alu_result  in  WIDTH  from ALU, registered one cycle after inputs
alu_zero, alu_overflow  in  1  from ALU
busy  out  1  state != IDLE

Behaviour:
- Clock and reset: clk; reset is asynchronous and active-high.
- Reset values: state IDLE; last_grant=1, so port 0 wins the first tie. All ready/valid outputs 0. alu_a, alu_b, alu_ctrl, rsp_* all 0; alu_ctrl=0000 is the ALU default and produces a zero result.
- FSM states: IDLE, ISSUE, CAPTURE, RESP.
- IDLE:
  - If any reqN_valid, grant via round-robin: on a tie, grant the port not equal to last_grant.
  - Assert reqN_ready combinationally for the granted port only.
  - Latch op, a, b, tag and the grant.
  - Legal op set: 0010, 0011, 0100–1101. If the op is legal, go to ISSUE. If illegal, load rsp_err=1, rsp_result=0, rsp_zero=0, rsp_overflow=0 and go directly to RESP without touching the ALU.
- ISSUE: alu_a, alu_b and alu_ctrl are driven from the latched registers and held constant. The ALU registers its result at the end of this cycle. Go to CAPTURE.
- CAPTURE: sample alu_result into rsp_result and alu_zero into rsp_zero. Set rsp_overflow = alu_overflow only for op in {0010, 0011, 1011, 1100}, else 0. Set rsp_err=0. Return alu_ctrl to 0000. Go to RESP.
- RESP:
  - rspN_valid=1 for the granted port. rsp_* are held stable until the handshake completes.
  - On rspN_ready=1, clear valid, set last_grant = granted port, go to IDLE.
  - Backpressure is unbounded; the other port waits.
- Latency: accept→rsp_valid = 3 cycles for legal ops, 1 cycle for illegal ops. Peak throughput is 1 op per 4 cycles with zero response backpressure.
- No request is accepted outside IDLE; reqN_ready=0 in ISSUE/CAPTURE/RESP.
- Requests must hold op/a/b/tag stable while valid and not ready.
- Reset mid-operation: the in-flight transaction is dropped with no response; outputs return to reset values immediately.
- A request with valid deasserted before ready is ignored; no partial accept.

Decomposition:
- Shared package alu_pkg:
  - opcode constants OP_ADD=0010, OP_SUB=0011, OP_AND=0100, OP_OR=0101, OP_XOR=0110, OP_NOT=0111, OP_SLL=1000, OP_SRL=1001, OP_NOR=1010, OP_SUBU=1011, OP_ADDU=1100, OP_SLT=1101, OP_NOP=0000;
  - function is_legal_op;
  - function ovf_meaningful;
  - FSM state encoding.
- One sub-module, rr_arb2: 2-way round-robin grant with last_grant input, used in IDLE.

Test Plan:
- Reset then port 0 request ADD a=5, b=7, tag=3 → req0_ready in cycle 0; 3 cycles later rsp0_valid=1, rsp_result=12, rsp_zero=0, rsp_overflow=0, rsp_err=0, rsp_tag=3.
- Both ports valid from reset: port 0 AND a=FFFF0000, b=0F0F0F0F; port 1 OR a=1, b=2 → port 0 is served first (result 0F0F0000), then port 1 (result 3), then the grant alternates on the next tie.
- Port 1 op=1111 → req1_ready, then 1 cycle later rsp1_valid=1, rsp_err=1, rsp_result=0; alu_ctrl stays 0000 throughout.
- Port 0 AND with alu_overflow forced to 1 by the ALU model → rsp_overflow=0. Port 0 SUB 5−5 → rsp_result=0, rsp_zero=1.
- Hold rsp0_ready=0 for 10 cycles while port 1 is valid → rsp0 data stable, req1_ready stays 0, busy=1. Release rsp0_ready → port 1 is accepted the following cycle.
- Assert reset during CAPTURE → rsp0_valid never rises, busy=0, all outputs return to 0. The next request completes normally.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sharing controller: opcodes, legality and overflow screens, FSM encoding.
// Purely combinational helpers; no latency.
// No flow control of its own.
package alu_pkg;

  localparam logic [3:0] OP_NOP  = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0011;
  localparam logic [3:0] OP_AND  = 4'b0100;
  localparam logic [3:0] OP_OR   = 4'b0101;
  localparam logic [3:0] OP_XOR  = 4'b0110;
  localparam logic [3:0] OP_NOT  = 4'b0111;
  localparam logic [3:0] OP_SLL  = 4'b1000;
  localparam logic [3:0] OP_SRL  = 4'b1001;
  localparam logic [3:0] OP_NOR  = 4'b1010;
  localparam logic [3:0] OP_SUBU = 4'b1011;
  localparam logic [3:0] OP_ADDU = 4'b1100;
  localparam logic [3:0] OP_SLT  = 4'b1101;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_RESP    = 2'd3
  } state_t;

  // Legal: ADD, SUB and the contiguous block AND..SLT.
  function automatic logic is_legal_op(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || ((op >= OP_AND) && (op <= OP_SLT));
  endfunction

  // Overflow only carries meaning for the add/subtract family.
  function automatic logic ovf_meaningful(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_SUBU) || (op == OP_ADDU);
  endfunction

endpackage

// File: rtl/alu_share_ctrl_if.sv
// Bundle of the two request/response ports plus the ALU-facing signals.
// slave: controller view; master: requesters + ALU view.
// Valid/ready on both request and response sides.
interface alu_share_ctrl_if #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
);
  logic             req0_valid, req1_valid;
  logic             req0_ready, req1_ready;
  logic [3:0]       req0_op, req1_op;
  logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [TAG_W-1:0] req0_tag, req1_tag;

  logic             rsp0_valid, rsp1_valid;
  logic             rsp0_ready, rsp1_ready;
  logic [WIDTH-1:0] rsp_result;
  logic             rsp_zero, rsp_overflow, rsp_err;
  logic [TAG_W-1:0] rsp_tag;

  logic [WIDTH-1:0] alu_a, alu_b;
  logic [3:0]       alu_ctrl;
  logic [WIDTH-1:0] alu_result;
  logic             alu_zero, alu_overflow;

  logic             busy;

  modport slave (
    input  req0_valid, req1_valid, req0_op, req1_op, req0_a, req0_b, req1_a, req1_b,
           req0_tag, req1_tag, rsp0_ready, rsp1_ready, alu_result, alu_zero, alu_overflow,
    output req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_result, rsp_zero,
           rsp_overflow, rsp_err, rsp_tag, alu_a, alu_b, alu_ctrl, busy
  );

  modport master (
    output req0_valid, req1_valid, req0_op, req1_op, req0_a, req0_b, req1_a, req1_b,
           req0_tag, req1_tag, rsp0_ready, rsp1_ready, alu_result, alu_zero, alu_overflow,
    input  req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_result, rsp_zero,
           rsp_overflow, rsp_err, rsp_tag, alu_a, alu_b, alu_ctrl, busy
  );
endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin grant; ties go to the port that was not granted last.
// Combinational, zero latency.
// No backpressure; caller qualifies the grant with its own state.
// Ports: req0/req1 requests, last_grant history bit, gnt_any/gnt_port result.
module rr_arb2 (
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  output logic gnt_any,
  output logic gnt_port
);
  always_comb begin
    gnt_any  = req0 | req1;
    gnt_port = 1'b0;
    if (req0 && req1) gnt_port = ~last_grant;
    else              gnt_port = req1;
  end
endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one registered ALU between two requesters, one op at a time, round-robin.
// Latency accept->rsp valid: 3 cycles legal op, 1 cycle illegal op.
// Accepts only in IDLE; response held until consumed, other port stalls meanwhile.
// Ports: clk, reset (async, active-high), bus (slave view of alu_share_ctrl_if).
module alu_share_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
) (
  input  logic            clk,
  input  logic            reset,
  alu_share_ctrl_if.slave bus
);

  state_t           state, state_nxt;
  logic             last_grant, grant_q;
  logic             gnt_any, gnt_port, accept, rsp_done;
  logic [3:0]       req_op, op_q;
  logic [WIDTH-1:0] req_a, req_b, a_q, b_q, result_q;
  logic [TAG_W-1:0] req_tag, tag_q;
  logic             zero_q, ovf_q, err_q;

  rr_arb2 u_arb (
    .req0       (bus.req0_valid),
    .req1       (bus.req1_valid),
    .last_grant (last_grant),
    .gnt_any    (gnt_any),
    .gnt_port   (gnt_port)
  );

  always_comb begin
    if (gnt_port) begin
      req_op  = bus.req1_op;
      req_a   = bus.req1_a;
      req_b   = bus.req1_b;
      req_tag = bus.req1_tag;
    end else begin
      req_op  = bus.req0_op;
      req_a   = bus.req0_a;
      req_b   = bus.req0_b;
      req_tag = bus.req0_tag;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    accept         = 1'b0;
    rsp_done       = 1'b0;
    bus.req0_ready = 1'b0;
    bus.req1_ready = 1'b0;
    bus.rsp0_valid = 1'b0;
    bus.rsp1_valid = 1'b0;
    case (state)
      ST_IDLE: begin
        // Reset gating keeps ready low while reset is held with a request pending.
        if (gnt_any && !reset) begin
          accept         = 1'b1;
          bus.req0_ready = ~gnt_port;
          bus.req1_ready = gnt_port;
          state_nxt      = is_legal_op(req_op) ? ST_ISSUE : ST_RESP;
        end
      end
      ST_ISSUE:   state_nxt = ST_CAPTURE;
      ST_CAPTURE: state_nxt = ST_RESP;
      ST_RESP: begin
        bus.rsp0_valid = ~grant_q;
        bus.rsp1_valid = grant_q;
        if (grant_q ? bus.rsp1_ready : bus.rsp0_ready) begin
          rsp_done  = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant <= 1'b1;
      grant_q    <= 1'b0;
      op_q       <= OP_NOP;
      a_q        <= '0;
      b_q        <= '0;
      tag_q      <= '0;
      result_q   <= '0;
      zero_q     <= 1'b0;
      ovf_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      if (accept) begin
        grant_q <= gnt_port;
        op_q    <= req_op;
        tag_q   <= req_tag;
        if (is_legal_op(req_op)) begin
          a_q <= req_a;
          b_q <= req_b;
        end else begin
          // Illegal op bypasses the ALU entirely; the response is synthesised here.
          result_q <= '0;
          zero_q   <= 1'b0;
          ovf_q    <= 1'b0;
          err_q    <= 1'b1;
        end
      end
      if (state == ST_CAPTURE) begin
        result_q <= bus.alu_result;
        zero_q   <= bus.alu_zero;
        ovf_q    <= bus.alu_overflow & ovf_meaningful(op_q);
        err_q    <= 1'b0;
      end
      if (rsp_done) last_grant <= grant_q;
    end
  end

  // Control is only presented during ISSUE, so the ALU sees NOP otherwise.
  assign bus.alu_ctrl     = (state == ST_ISSUE) ? op_q : OP_NOP;
  assign bus.alu_a        = a_q;
  assign bus.alu_b        = b_q;
  assign bus.rsp_result   = result_q;
  assign bus.rsp_zero     = zero_q;
  assign bus.rsp_overflow = ovf_q;
  assign bus.rsp_err      = err_q;
  assign bus.rsp_tag      = tag_q;
  assign bus.busy         = (state != ST_IDLE);

endmodule

// File: tb/tb_alu_share_ctrl.sv
module tb_alu_share_ctrl;
  localparam int WIDTH = 32;
  localparam int TAG_W = 4;

  logic clk;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic model_last;
  logic force_ovf;

  logic             pv[2];
  logic [3:0]       pop[2];
  logic [WIDTH-1:0] pa[2], pb[2];
  logic [TAG_W-1:0] ptag[2];
  logic             rr[2];

  alu_share_ctrl_if #(.WIDTH(WIDTH), .TAG_W(TAG_W)) bus ();

  alu_share_ctrl #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Reference ALU behaviour from the opcode table.
  function automatic logic [WIDTH-1:0] ref_res(input logic [3:0] op, input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
    case (op)
      4'd2, 4'd12: return a + b;
      4'd3, 4'd11: return a - b;
      4'd4:        return a & b;
      4'd5:        return a | b;
      4'd6:        return a ^ b;
      4'd7:        return ~a;
      4'd8:        return a << b[4:0];
      4'd9:        return a >> b[4:0];
      4'd10:       return ~(a | b);
      4'd13:       return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default:     return '0;
    endcase
  endfunction

  function automatic logic ref_ovf(input logic [3:0] op, input logic [WIDTH-1:0] a,
                                   input logic [WIDTH-1:0] b);
    longint sa, sb, s;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (op == 4'd2 || op == 4'd12)      s = sa + sb;
    else if (op == 4'd3 || op == 4'd11) s = sa - sb;
    else return 1'b0;
    return (s > 64'sd2147483647) || (s < -64'sd2147483648);
  endfunction

  function automatic logic legal(input logic [3:0] op);
    return op inside {4'd2, 4'd3, [4'd4:4'd13]};
  endfunction

  function automatic logic ovf_counts(input logic [3:0] op);
    return op inside {4'd2, 4'd3, 4'd11, 4'd12};
  endfunction

  // Registered ALU model: one-cycle latency from operands/control to result.
  always @(posedge clk) begin
    bus.alu_result   <= ref_res(bus.alu_ctrl, bus.alu_a, bus.alu_b);
    bus.alu_zero     <= (ref_res(bus.alu_ctrl, bus.alu_a, bus.alu_b) == '0);
    bus.alu_overflow <= force_ovf | ref_ovf(bus.alu_ctrl, bus.alu_a, bus.alu_b);
  end

  function automatic logic rdy(input int p);
    return (p != 0) ? bus.req1_ready : bus.req0_ready;
  endfunction

  function automatic logic rspv(input int p);
    return (p != 0) ? bus.rsp1_valid : bus.rsp0_valid;
  endfunction

  task automatic apply();
    bus.req0_valid = pv[0];  bus.req1_valid = pv[1];
    bus.req0_op    = pop[0]; bus.req1_op    = pop[1];
    bus.req0_a     = pa[0];  bus.req1_a     = pa[1];
    bus.req0_b     = pb[0];  bus.req1_b     = pb[1];
    bus.req0_tag   = ptag[0]; bus.req1_tag  = ptag[1];
    bus.rsp0_ready = rr[0];  bus.rsp1_ready = rr[1];
  endtask

  task automatic set_req(input int p, input logic [3:0] op, input logic [WIDTH-1:0] a,
                         input logic [WIDTH-1:0] b, input logic [TAG_W-1:0] tag);
    pv[p] = 1'b1; pop[p] = op; pa[p] = a; pb[p] = b; ptag[p] = tag;
  endtask

  // Serve one pending request end to end; entered and left just after a negedge in IDLE.
  task automatic serve_one(input string name, output int waited);
    int e, lat;
    logic [3:0] op;
    logic [WIDTH-1:0] er;
    logic eo, ee;
    logic [3:0] ctrl1;
    apply();
    #1;
    e = (pv[0] && pv[1]) ? int'(!model_last) : int'(pv[1]);
    waited = 0;
    while (rdy(e) !== 1'b1 && waited < 20) begin
      @(negedge clk); #1; waited++;
    end
    n_checks++;
    if (rdy(e) !== 1'b1) begin n_fail++; $display("FAIL %s grant: port %0d ready=%b required 1", name, e, rdy(e)); end
    n_checks++;
    if (rdy(1 - e) !== 1'b0) begin n_fail++; $display("FAIL %s other_ready: port %0d ready=%b required 0", name, 1 - e, rdy(1 - e)); end
    n_checks++;
    if (bus.alu_ctrl !== 4'd0) begin n_fail++; $display("FAIL %s idle_ctrl: alu_ctrl=%h required 0", name, bus.alu_ctrl); end
    op = pop[e];
    if (legal(op)) begin
      er = ref_res(op, pa[e], pb[e]);
      eo = ovf_counts(op) & (force_ovf | ref_ovf(op, pa[e], pb[e]));
      ee = 1'b0;
    end else begin
      er = '0; eo = 1'b0; ee = 1'b1;
    end
    @(negedge clk);
    pv[e] = 1'b0;
    apply();
    #1;
    ctrl1 = bus.alu_ctrl;
    lat = 1;
    while (rspv(e) !== 1'b1 && lat < 20) begin
      @(negedge clk); #1; lat++;
    end
    n_checks++;
    if (ctrl1 !== (legal(op) ? op : 4'd0)) begin n_fail++; $display("FAIL %s issue_ctrl: alu_ctrl=%h required %h", name, ctrl1, legal(op) ? op : 4'd0); end
    n_checks++;
    if (lat !== (legal(op) ? 3 : 1)) begin n_fail++; $display("FAIL %s latency: got %0d required %0d", name, lat, legal(op) ? 3 : 1); end
    n_checks++;
    if (bus.rsp_result !== er) begin n_fail++; $display("FAIL %s result: got %h required %h (op %h)", name, bus.rsp_result, er, op); end
    n_checks++;
    if (bus.rsp_zero !== (legal(op) && er == '0)) begin n_fail++; $display("FAIL %s zero: got %b required %b", name, bus.rsp_zero, legal(op) && er == '0); end
    n_checks++;
    if (bus.rsp_overflow !== eo) begin n_fail++; $display("FAIL %s overflow: got %b required %b (op %h)", name, bus.rsp_overflow, eo, op); end
    n_checks++;
    if (bus.rsp_err !== ee) begin n_fail++; $display("FAIL %s err: got %b required %b", name, bus.rsp_err, ee); end
    n_checks++;
    if (bus.rsp_tag !== ptag[e]) begin n_fail++; $display("FAIL %s tag: got %h required %h", name, bus.rsp_tag, ptag[e]); end
    n_checks++;
    if (rspv(1 - e) !== 1'b0) begin n_fail++; $display("FAIL %s other_valid: port %0d rsp valid=%b required 0", name, 1 - e, rspv(1 - e)); end
    @(negedge clk);
    model_last = e[0];
  endtask

  task automatic test_reset();
    reset = 1'b1;
    set_req(0, 4'd2, 32'd1, 32'd1, 4'd1);
    apply();
    #12;
    n_checks++;
    if ({bus.req0_ready, bus.req1_ready, bus.rsp0_valid, bus.rsp1_valid, bus.busy} !== 5'b0) begin
      n_fail++; $display("FAIL reset_handshake: got %b required 00000",
                         {bus.req0_ready, bus.req1_ready, bus.rsp0_valid, bus.rsp1_valid, bus.busy});
    end
    n_checks++;
    if ({bus.alu_a, bus.alu_b, bus.alu_ctrl} !== '0) begin
      n_fail++; $display("FAIL reset_alu: a=%h b=%h ctrl=%h required 0", bus.alu_a, bus.alu_b, bus.alu_ctrl);
    end
    n_checks++;
    if ({bus.rsp_result, bus.rsp_zero, bus.rsp_overflow, bus.rsp_err, bus.rsp_tag} !== '0) begin
      n_fail++; $display("FAIL reset_rsp: result=%h z=%b o=%b e=%b tag=%h required 0",
                         bus.rsp_result, bus.rsp_zero, bus.rsp_overflow, bus.rsp_err, bus.rsp_tag);
    end
    pv[0] = 1'b0;
    apply();
    @(negedge clk);
    reset = 1'b0;
    model_last = 1'b1;
  endtask

  task automatic test_basic_add();
    int w;
    set_req(0, 4'd2, 32'd5, 32'd7, 4'd3);
    serve_one("basic_add", w);
    n_checks++;
    if (w !== 0) begin n_fail++; $display("FAIL basic_add_wait: waited %0d cycles required 0", w); end
  endtask

  task automatic test_tie();
    int w;
    set_req(0, 4'd4, 32'hFFFF0000, 32'h0F0F0F0F, 4'd1);
    set_req(1, 4'd5, 32'd1, 32'd2, 4'd2);
    while (pv[0] || pv[1]) serve_one("tie1", w);
    // Last served was port 1, so the next tie must go to port 0, then alternate.
    set_req(0, 4'd6, 32'h1234, 32'h00FF, 4'd7);
    set_req(1, 4'd13, 32'hFFFFFFFF, 32'd1, 4'd8);
    while (pv[0] || pv[1]) serve_one("tie2", w);
  endtask

  task automatic test_illegal();
    int w;
    set_req(1, 4'hF, 32'hDEAD, 32'hBEEF, 4'd9);
    serve_one("illegal_f", w);
    set_req(0, 4'h0, 32'h1, 32'h2, 4'd10);
    serve_one("illegal_0", w);
    set_req(1, 4'hE, 32'h5, 32'h6, 4'd11);
    serve_one("illegal_e", w);
  endtask

  task automatic test_ovf_mask();
    int w;
    force_ovf = 1'b1;
    set_req(0, 4'd4, 32'hF0, 32'h3C, 4'd4);
    serve_one("ovf_and", w);
    set_req(0, 4'd2, 32'd1, 32'd2, 4'd5);
    serve_one("ovf_add_forced", w);
    force_ovf = 1'b0;
    set_req(0, 4'd3, 32'd5, 32'd5, 4'd6);
    serve_one("sub_zero", w);
    set_req(1, 4'd2, 32'h7FFFFFFF, 32'd1, 4'd12);
    serve_one("add_ovf", w);
  endtask

  task automatic test_backpressure();
    int w;
    logic [WIDTH-1:0] snap;
    set_req(0, 4'd2, 32'd100, 32'd23, 4'd5);
    rr[0] = 1'b0;
    apply();
    #1;
    n_checks++;
    if (bus.req0_ready !== 1'b1) begin n_fail++; $display("FAIL bp_accept: req0_ready=%b required 1", bus.req0_ready); end
    @(negedge clk);
    pv[0] = 1'b0;
    set_req(1, 4'd3, 32'd9, 32'd4, 4'd6);
    apply();
    #1;
    w = 0;
    while (bus.rsp0_valid !== 1'b1 && w < 10) begin @(negedge clk); #1; w++; end
    snap = bus.rsp_result;
    n_checks++;
    if (snap !== 32'd123) begin n_fail++; $display("FAIL bp_result: got %h required %h", snap, 32'd123); end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      n_checks++;
      if ({bus.rsp0_valid, bus.req1_ready, bus.busy, bus.rsp_result, bus.rsp_tag} !== {3'b101, snap, 4'd5}) begin
        n_fail++; $display("FAIL bp_hold[%0d]: rsp0_valid=%b req1_ready=%b busy=%b result=%h tag=%h required 1 0 1 %h 5",
                           i, bus.rsp0_valid, bus.req1_ready, bus.busy, bus.rsp_result, bus.rsp_tag, snap);
      end
    end
    rr[0] = 1'b1;
    apply();
    @(negedge clk);
    model_last = 1'b0;
    serve_one("bp_port1", w);
    n_checks++;
    if (w !== 0) begin n_fail++; $display("FAIL bp_release_wait: waited %0d cycles required 0", w); end
  endtask

  task automatic test_reset_mid();
    int w;
    logic seen;
    set_req(0, 4'd2, 32'd1, 32'd2, 4'd9);
    apply();
    #1;
    n_checks++;
    if (bus.req0_ready !== 1'b1) begin n_fail++; $display("FAIL rst_mid_accept: req0_ready=%b required 1", bus.req0_ready); end
    @(negedge clk);
    pv[0] = 1'b0;
    apply();
    @(negedge clk);
    reset = 1'b1;
    #1;
    n_checks++;
    if ({bus.busy, bus.rsp0_valid, bus.rsp1_valid, bus.req0_ready, bus.req1_ready} !== 5'b0) begin
      n_fail++; $display("FAIL rst_mid_ctrl: busy=%b rsp0_valid=%b required 0", bus.busy, bus.rsp0_valid);
    end
    n_checks++;
    if ({bus.alu_a, bus.alu_b, bus.alu_ctrl, bus.rsp_result, bus.rsp_tag, bus.rsp_err} !== '0) begin
      n_fail++; $display("FAIL rst_mid_data: a=%h b=%h ctrl=%h result=%h tag=%h err=%b required 0",
                         bus.alu_a, bus.alu_b, bus.alu_ctrl, bus.rsp_result, bus.rsp_tag, bus.rsp_err);
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_last = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      if (bus.rsp0_valid !== 1'b0 || bus.busy !== 1'b0) seen = 1'b1;
    end
    n_checks++;
    if (seen !== 1'b0) begin n_fail++; $display("FAIL rst_mid_dropped: stray activity=%b required 0", seen); end
    @(negedge clk);
    set_req(0, 4'd12, 32'd40, 32'd2, 4'd3);
    serve_one("rst_mid_after", w);
  endtask

  task automatic test_random();
    int w;
    logic [3:0] op;
    for (int it = 0; it < 40; it++) begin
      force_ovf = ($urandom_range(0, 3) == 0);
      for (int p = 0; p < 2; p++) begin
        if ($urandom_range(0, 1) == 1 || (p == 1 && !pv[0])) begin
          op = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(2, 13));
          set_req(p, op, $urandom, ($urandom_range(0, 4) == 0) ? pa[p] : $urandom, 4'($urandom_range(0, 15)));
          if ($urandom_range(0, 4) == 0) pb[p] = pa[p];
        end
      end
      while (pv[0] || pv[1]) serve_one("random", w);
    end
    force_ovf = 1'b0;
  endtask

  initial begin
    force_ovf = 1'b0;
    for (int p = 0; p < 2; p++) begin
      pv[p] = 1'b0; pop[p] = '0; pa[p] = '0; pb[p] = '0; ptag[p] = '0; rr[p] = 1'b1;
    end
    apply();
    model_last = 1'b1;
    test_reset();
    test_basic_add();
    test_tie();
    test_illegal();
    test_ovf_mask();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
